// File: rtl/atc_pkg.sv
// rtl/atc_pkg.sv - shared constants and types for the approximate tree compressor datapath
package atc_pkg;

  localparam int ATC_WORD_SIZE = 9;
  localparam int ATC_ROWS      = 4;
  localparam int ATC_RES_W     = ATC_WORD_SIZE + 2 * ATC_ROWS - 1;

  typedef logic [ATC_WORD_SIZE-1:0] atc_row_t;
  typedef atc_row_t [ATC_ROWS-1:0]  atc_rows_t;
  typedef logic [ATC_RES_W-1:0]     atc_result_t;

endpackage

// File: rtl/atc_pipe_reg.sv
// rtl/atc_pipe_reg.sv - generic valid/ready register slice with synchronous flush
module atc_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  // Accept when empty or when the held entry leaves this cycle; flush blocks any accept.
  assign in_ready = !flush && (!r_valid || out_ready);
  assign w_load   = in_valid && in_ready;

  // Flush empties the slice; otherwise a load fills it and a consume without a load drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload moves only on an accepted load, so it is stable during stalls and across a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_load) begin
      r_data <= in_data;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

endmodule

// File: rtl/atc_final_adder.sv
// rtl/atc_final_adder.sv - two-stage final adder; ATC_ERR_RECOVERY_EN adds the error-recovery vector
module atc_final_adder
  import atc_pkg::*;
#(
  parameter int WORD_SIZE = ATC_WORD_SIZE,
  parameter int ROWS      = ATC_ROWS,
  parameter int RES_W     = WORD_SIZE + 2 * ROWS - 1,
  parameter int TAG_W     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ROWS*WORD_SIZE-1:0] in_rows,
  input  logic [WORD_SIZE-1:0]      in_vec,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [RES_W-1:0]          out_result,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int S1_W = 2 * RES_W + TAG_W;
  localparam int S2_W = RES_W + TAG_W;

  // The reduction below is written for exactly four rows.
  if (ROWS != 4) begin : g_rows_check
    $error("atc_final_adder supports ROWS == 4 only");
  end

  logic [RES_W-1:0] w_row0, w_row1, w_row2, w_row3, w_vec;
  logic [RES_W-1:0] w_s1_lo, w_s1_hi;
  logic [S1_W-1:0]  w_s1_d, w_s1_q;
  logic             w_s1_valid, w_s2_in_ready;
  logic [RES_W-1:0] w_q_lo, w_q_hi;
  logic [TAG_W-1:0] w_q_tag;
  logic [S2_W-1:0]  w_s2_d, w_s2_q;

  assign w_row0 = RES_W'(in_rows[0*WORD_SIZE +: WORD_SIZE]);
  assign w_row1 = RES_W'(in_rows[1*WORD_SIZE +: WORD_SIZE]);
  assign w_row2 = RES_W'(in_rows[2*WORD_SIZE +: WORD_SIZE]);
  assign w_row3 = RES_W'(in_rows[3*WORD_SIZE +: WORD_SIZE]);

`ifdef ATC_ERR_RECOVERY_EN
  assign w_vec = RES_W'(in_vec);
`else
  // Vector port kept for integration; the purely approximate product ignores it.
  logic w_unused_vec;
  assign w_unused_vec = ^in_vec;
  assign w_vec        = '0;
`endif

  // Row i carries weight 4^i; the vector (when enabled) sits at weight 1 in the low half.
  assign w_s1_lo = w_row0 + (w_row1 << 2) + w_vec;
  assign w_s1_hi = (w_row2 << 4) + (w_row3 << 6);
  assign w_s1_d  = {w_s1_lo, w_s1_hi, in_tag};

  atc_pipe_reg #(.W(S1_W)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_s1_d),
    .out_valid (w_s1_valid),
    .out_ready (w_s2_in_ready),
    .out_data  (w_s1_q)
  );

  assign w_q_lo  = w_s1_q[S1_W-1 -: RES_W];
  assign w_q_hi  = w_s1_q[TAG_W +: RES_W];
  assign w_q_tag = w_s1_q[TAG_W-1:0];
  assign w_s2_d  = {w_q_lo + w_q_hi, w_q_tag};

  atc_pipe_reg #(.W(S2_W)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (w_s1_valid),
    .in_ready  (w_s2_in_ready),
    .in_data   (w_s2_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_s2_q)
  );

  assign out_result = w_s2_q[S2_W-1 -: RES_W];
  assign out_tag    = w_s2_q[TAG_W-1:0];

endmodule

// File: tb/tb_atc_final_adder.sv
// tb/tb_atc_final_adder.sv - scoreboard bench for atc_final_adder
module tb_atc_final_adder;
  import atc_pkg::*;

  localparam int WS = ATC_WORD_SIZE;
  localparam int RW = ATC_RES_W;
  localparam int TW = 4;
`ifdef ATC_ERR_RECOVERY_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4*WS-1:0] in_rows = '0;
  logic [WS-1:0] in_vec = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_result;
  logic [TW-1:0] out_tag;

  typedef struct packed {
    logic [RW-1:0] res;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_fail = 0;
  int n_acc = 0;
  int n_out = 0;

  atc_final_adder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rows    (in_rows),
    .in_vec     (in_vec),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] model(input logic [4*WS-1:0] r, input logic [WS-1:0] v,
                                          input bit en);
    logic [RW-1:0] s;
    s = '0;
    for (int i = 0; i < 4; i++) s = s + (RW'(r[i*WS +: WS]) << (2 * i));
    if (en) s = s + RW'(v);
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic rand_rows();
    for (int i = 0; i < 4; i++) in_rows[i*WS +: WS] = WS'($urandom_range(0, 511));
    in_vec = WS'($urandom_range(0, 511));
  endtask

  // One clock: settle, score the handshakes of this cycle, advance to just after the next edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(out_result), 32'(e.res));
        check("tag", 32'(out_tag), 32'(e.tag));
      end
    end
    if (flush) sb.delete();
    if (in_valid && in_ready) begin
      n_acc++;
      sb.push_back('{res: model(in_rows, in_vec, ERR_EN), tag: in_tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && k < bound) begin
      cycle();
      k++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base_acc, base_out, next_tag, k;
    logic [RW-1:0] held;
    logic [RW-1:0] exp_max;

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Unit weights, latency
    in_rows = {9'd1, 9'd1, 9'd1, 9'd1};
    in_vec = '0;
    in_tag = 4'd3;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("unit_valid_early", 32'(out_valid), 32'd0);
    cycle();
    check("unit_valid", 32'(out_valid), 32'd1);
    check("unit_result", 32'(out_result), 32'd85);
    check("unit_tag", 32'(out_tag), 32'd3);
    drain(5);

    // Maximum operands
    exp_max = ERR_EN ? RW'(43946) : RW'(43435);
    in_rows = '1;
    in_vec = '1;
    in_tag = 4'd5;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("max_result", 32'(out_result), 32'(exp_max));
    drain(5);

    // Backpressure: tags 0..9 with downstream stalled for 5 cycles
    base_acc = n_acc;
    base_out = n_out;
    next_tag = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_tag = 4'd0;
    rand_rows();
    held = '0;
    for (int c = 0; c < 5; c++) begin
      k = n_acc;
      cycle();
      if (n_acc != k) begin
        next_tag++;
        in_tag = TW'(next_tag);
        rand_rows();
      end
      if (c == 2) held = out_result;
    end
    check("bp_accepts", 32'(n_acc - base_acc), 32'd2);
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_stable", 32'(out_result), 32'(held));
    check("bp_tag_held", 32'(out_tag), 32'd0);
    out_ready = 1'b1;
    k = 0;
    while (next_tag < 10 && k < 50) begin
      base_acc = n_acc;
      cycle();
      if (n_acc != base_acc) begin
        next_tag++;
        in_tag = TW'(next_tag);
        rand_rows();
      end
      k++;
    end
    check("bp_all_accepted", 32'(next_tag), 32'd10);
    drain(10);
    check("bp_all_delivered", 32'(n_out - base_out), 32'd10);

    // Random stall pattern
    base_acc = n_acc;
    base_out = n_out;
    k = 0;
    while ((n_acc - base_acc) < 1000 && k < 20000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = $urandom_range(0, 1) == 1;
      in_tag = TW'($urandom_range(0, 15));
      rand_rows();
      cycle();
      k++;
    end
    check("rand_accepts", 32'(n_acc - base_acc), 32'd1000);
    drain(10);
    check("rand_delivered", 32'(n_out - base_out), 32'd1000);

    // Flush with both stages full and input pending
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_tag = TW'(c + 1);
      rand_rows();
      cycle();
    end
    check("flush_full", 32'(out_valid), 32'd1);
    base_acc = n_acc;
    flush = 1'b1;
    in_tag = 4'd9;
    #1;
    check("flush_blocks_in", 32'(in_ready), 32'd0);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_no_accept", 32'(n_acc - base_acc), 32'd0);
    base_out = n_out;
    in_valid = 1'b1;
    in_tag = 4'd7;
    rand_rows();
    out_ready = 1'b1;
    cycle();
    drain(5);
    check("flush_next_op", 32'(n_out - base_out), 32'd1);

    // Reset mid-stream, asserted between edges
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_tag = TW'(c + 12);
      rand_rows();
      cycle();
    end
    rst_n = 1'b0;
    #1;
    check("amid_rst_valid", 32'(out_valid), 32'd0);
    check("amid_rst_result", 32'(out_result), 32'd0);
    check("amid_rst_tag", 32'(out_tag), 32'd0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    in_rows = {9'd3, 9'd100, 9'd511, 9'd7};
    in_vec = 9'd200;
    in_tag = 4'd11;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("post_rst_early", 32'(out_valid), 32'd0);
    cycle();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_result", 32'(out_result),
          32'(ERR_EN ? RW'(7 + 511*4 + 100*16 + 3*64 + 200) : RW'(7 + 511*4 + 100*16 + 3*64)));
    check("post_rst_tag", 32'(out_tag), 32'd11);
    drain(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
